// File: rtl/imem_pkg.sv
// Shared constants and types for the synchronous instruction memory.
package imem_pkg;

  // Widest instruction word the NOP constant covers.
  localparam int MAX_DATA_W = 64;

  // Instruction returned on any fault; all-zeros decodes as sll $0,$0,0.
  localparam logic [MAX_DATA_W-1:0] NOP_WORD = '0;

  // Fault code: bit0 misaligned PC, bit1 PC beyond the array.
  typedef logic [1:0] fault_t;

  localparam fault_t FAULT_NONE     = 2'b00;
  localparam fault_t FAULT_MISALIGN = 2'b01;
  localparam fault_t FAULT_RANGE    = 2'b10;

  // Word-index width for a given depth; never below 1 so ports stay legal.
  function automatic int idx_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one registered read
// port with read-enable. No reset on the storage, so it maps onto block RAM.
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Read-data register holds unless a new read is enabled.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_idx];
    end
  end

  // Storage write and read-data capture share the clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with valid/ready fetch, one-entry
// response register, program-load port, fault reporting and a saturating
// count of accepted fetches.
module imem_sync
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic [ADDR_W-1:0]        rsp_pc,
  output logic [1:0]               rsp_fault,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_idx,
  input  logic [DATA_W-1:0]        prog_data,
  output logic [CNT_W-1:0]         fetch_cnt
);

  localparam int IDX_W = idx_w(DEPTH);

  logic              accept;
  logic              misalign;
  logic              range_err;
  logic [ADDR_W-1:0] pc_upper;
  logic [IDX_W-1:0]  req_idx;
  fault_t            req_fault;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  logic              rsp_valid_d, rsp_valid_q;
  logic [ADDR_W-1:0] rsp_pc_d,    rsp_pc_q;
  fault_t            rsp_fault_d, rsp_fault_q;
  logic              has_data_d,  has_data_q;
  logic [CNT_W-1:0]  fetch_cnt_d, fetch_cnt_q;

  // Decode the requested PC into a word index and fault code.
  always_comb begin
    misalign  = (req_pc[1:0] != 2'b00);
    pc_upper  = req_pc >> (IDX_W + 2);
    range_err = (pc_upper != '0);
    req_idx   = req_pc[IDX_W+1:2];
    req_fault = FAULT_NONE;
    if (misalign) begin
      req_fault = req_fault | FAULT_MISALIGN;
    end
    if (range_err) begin
      req_fault = req_fault | FAULT_RANGE;
    end
  end

  // Handshake: program load blocks fetches; a full register must drain first.
  always_comb begin
    req_ready = !prog_we && (!rsp_valid_q || rsp_ready);
    accept    = req_valid && req_ready;
    rd_en     = accept && (req_fault == FAULT_NONE);
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (prog_we),
    .wr_idx  (prog_idx),
    .wr_data (prog_data),
    .rd_en   (rd_en),
    .rd_idx  (req_idx),
    .rd_data (rd_data)
  );

  // Next state of the response register; new acceptance wins over drain.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_fault_d = rsp_fault_q;
    has_data_d  = has_data_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = req_pc;
      rsp_fault_d = req_fault;
      has_data_d  = (req_fault == FAULT_NONE);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Saturating count of accepted fetches, faulting ones included.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (accept && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
  end

  // Response and counter registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      rsp_fault_q <= FAULT_NONE;
      has_data_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_fault_q <= rsp_fault_d;
      has_data_q  <= has_data_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // The RAM read register is not reset, so instr shows NOP unless the
  // current response came from a fault-free read.
  always_comb begin
    rsp_instr = has_data_q ? rd_data : NOP_WORD[DATA_W-1:0];
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_fault = rsp_fault_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/imem_sync.md
# imem_sync

Parametrised, synchronous-read instruction memory for the MIPS single-cycle and upcoming pipelined datapaths. Replaces the fixed 32-word combinational ROM with a configurable-width/depth array that has:
- a valid/ready fetch handshake;
- a one-entry response register (1-cycle read latency, back-pressure capable);
- a word-write program-load port;
- alignment and range fault reporting;
- a saturating fetch counter.

It sits between the PC/fetch stage and the decode stage.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- DEPTH, 32, number of instruction words; power of two, minimum 2
- ADDR_W, 32, byte-address (PC) width
- CNT_W, 16, fetch-counter width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  fetch request can be accepted this cycle
- req_pc  in  ADDR_W  byte address of requested instruction
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts response this cycle
- rsp_instr  out  DATA_W  fetched instruction (NOP on fault)
- rsp_pc  out  ADDR_W  PC that produced this response
- rsp_fault  out  2  bit0 misaligned, bit1 out of range
- prog_we  in  1  program-load write strobe
- prog_idx  in  $clog2(DEPTH)  word index to write
- prog_data  in  DATA_W  word to write
- fetch_cnt  out  CNT_W  count of accepted fetches, saturating

## Operation
Word index and faults:
- idx = req_pc >> 2.
- Misaligned: req_pc[1:0] != 0.
- Out of range: idx >= DEPTH (any set bit of req_pc above bit $clog2(DEPTH)+1).

Acceptance:
- req_ready = !prog_we && (!rsp_valid || rsp_ready).
- A fetch is accepted when req_valid && req_ready.

On acceptance, at the next edge:
- rsp_valid <= 1
- rsp_pc <= req_pc
- rsp_fault <= {range, misaligned}
- rsp_instr <= array[idx] if no fault, else NOP_WORD (all zeros)

When both faults apply, both bits set; instr = NOP_WORD.

Response register:
- Holds its contents while rsp_valid && !rsp_ready.
- Clears rsp_valid when rsp_ready && rsp_valid and no new acceptance in the same cycle.
- Simultaneous drain and accept: new response is loaded and rsp_valid stays 1 (full throughput, one fetch per cycle).

Program load:
- prog_we writes array[prog_idx] <= prog_data at the edge.
- Priority over fetch: req_ready is forced low that cycle, so a fetch can never read a same-cycle write.
- The next accepted fetch of that index returns the new data.

fetch_cnt:
- Increments on every accepted fetch, including faulting ones.
- Saturates at all-ones.

Array contents:
- Not reset; retained across rst_n.
- Unwritten words read as X in simulation.
- Benches preload via prog port only.

## Timing
Reset values (asynchronous assertion, synchronous release on next clk edge):
- rsp_valid 0
- rsp_instr 0
- rsp_pc 0
- rsp_fault 0
- fetch_cnt 0
- req_ready evaluates to 1 (combinational, prog_we low)

Reset mid-operation: a pending response is dropped; no partial write occurs.

Latency and throughput:
- Read latency: exactly 1 cycle from acceptance edge to rsp_valid.
- Sustained throughput: 1 fetch/cycle while rsp_ready=1 and prog_we=0.

Handshake rules:
- req_pc must be stable only in the accepting cycle.
- Outputs are stable while rsp_valid && !rsp_ready.

Combinational paths: req_ready depends combinationally on rsp_ready and prog_we; there is no other combinational input-to-output path.

## Structure
Shared package imem_pkg holds:
- NOP_WORD
- FAULT_MISALIGN = 2'b01, FAULT_RANGE = 2'b10
- fault typedef (2-bit packed)
- index-width helper constant

One sub-module, imem_array:
- DEPTH x DATA_W storage
- one synchronous write port
- one synchronous registered read port with read-enable
- inferable as block RAM

imem_sync owns the handshake, fault logic, response register and counter.

## Test plan
- Reset then load words 0..3 = 0x20010002, 0x84010000, 0x04040004, 0x1C00001D; fetch pc 0,4,8,12 back-to-back with rsp_ready=1 -> four consecutive rsp_valid cycles, instr in order, fetch_cnt=4.
- Fetch pc=0x6 -> rsp_fault=01, rsp_instr=0; fetch pc=0x80 (DEPTH=32) -> rsp_fault=10; pc=0x81 -> rsp_fault=11.
- Hold rsp_ready=0 after one response -> req_ready=0, rsp_instr/rsp_pc unchanged for 5 cycles; release -> next queued fetch returns 1 cycle later.
- Assert prog_we idx=2 data=0xDEADBEEF with req_valid high -> req_ready=0 that cycle; following fetch pc=8 -> 0xDEADBEEF.
- Pulse rst_n low while rsp_valid=1 -> rsp_valid=0, fetch_cnt=0 asynchronously; re-fetch pc=4 -> previously loaded data intact.
- CNT_W=2, five accepted fetches -> fetch_cnt sticks at 3.
